// File: rtl/ib_pkg.sv
// rtl/ib_pkg.sv - shared constants and helpers for the instruction-buffer prefetch stage
package ib_pkg;

    localparam int IB_LW_BYTES = 4;

    localparam logic [1:0] IB_SHIFT_0 = 2'd0;
    localparam logic [1:0] IB_SHIFT_1 = 2'd1;
    localparam logic [1:0] IB_SHIFT_2 = 2'd2;

    function automatic int ib_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ib_byte_queue.sv
// rtl/ib_byte_queue.sv - byte queue with head retire (0..2 bytes) and longword append
module ib_byte_queue
    import ib_pkg::*;
#(
    parameter int DEPTH_BYTES = 8,
    parameter int CW          = ib_cnt_w(DEPTH_BYTES)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic [1:0]    shift_i,
    input  logic          fill_i,
    input  logic [31:0]   fill_data_i,
    input  logic [1:0]    fill_skip_i,
    output logic [CW-1:0] cnt_o,
    output logic [15:0]   head_o,
    output logic [1:0]    bvalid_o,
    output logic          err_o
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0]    q_q [DEPTH_BYTES];
    logic [7:0]    q_d [DEPTH_BYTES];
    logic [7:0]    fb  [IB_LW_BYTES];
    logic [CW-1:0] cnt_q, cnt_d, kept;
    logic [2:0]    sh_n, added;
    logic          shift_ok, err_q, err_d;

    always_comb begin
        case (shift_i)
            IB_SHIFT_0: sh_n = 3'd0;
            IB_SHIFT_1: sh_n = 3'd1;
            IB_SHIFT_2: sh_n = 3'd2;
            default:    sh_n = 3'd3;
        endcase
        shift_ok = (sh_n != 3'd3) && (CW'(sh_n) <= cnt_q);
        kept     = shift_ok ? cnt_q - CW'(sh_n) : cnt_q;
        err_d    = err_q | ~shift_ok;
        added    = fill_i ? 3'(IB_LW_BYTES) - {1'b0, fill_skip_i} : 3'd0;
        for (int k = 0; k < IB_LW_BYTES; k++) begin
            fb[k] = fill_data_i[8*k +: 8];
        end
        // Retire first, then append behind the surviving bytes.
        for (int i = 0; i < DEPTH_BYTES; i++) begin
            q_d[i] = q_q[i];
            if (shift_ok && (i + int'(sh_n)) < DEPTH_BYTES) begin
                q_d[i] = q_q[AW'(i + int'(sh_n))];
            end
        end
        for (int k = 0; k < IB_LW_BYTES; k++) begin
            if (k < int'(added) && (int'(kept) + k) < DEPTH_BYTES) begin
                q_d[AW'(int'(kept) + k)] = fb[2'(int'(fill_skip_i) + k)];
            end
        end
        cnt_d = kept + CW'(added);
        if (flush_i) begin
            cnt_d = '0;
            err_d = err_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                q_q[i] <= 8'h00;
            end
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                q_q[i] <= q_d[i];
            end
        end
    end

    // Slots past the valid count may hold stale bytes, so lanes are masked.
    assign bvalid_o = {cnt_q >= CW'(2), cnt_q >= CW'(1)};
    assign head_o   = {bvalid_o[1] ? q_q[1] : 8'h00, bvalid_o[0] ? q_q[0] : 8'h00};
    assign cnt_o    = cnt_q;
    assign err_o    = err_q;

endmodule

// File: rtl/ib_prefetch.sv
// rtl/ib_prefetch.sv - instruction-buffer prefetch: fetch control and address around the byte queue
module ib_prefetch
    import ib_pkg::*;
#(
    parameter int DEPTH_BYTES = 8
) (
    input  logic        buf_m_clk_l,
    input  logic        reset_h,
    input  logic        ld_pc_h,
    input  logic [31:0] pc_h,
    input  logic [1:0]  ib_shift_h,
    output logic        ib_req_h,
    output logic [29:0] ib_va_h,
    input  logic        mem_ack_h,
    input  logic [31:0] mem_data_h,
    output logic [15:0] xbuf_h,
    output logic [1:0]  ib_bvalid_h,
    output logic [3:0]  ib_cnt_h,
    output logic        ib_err_h
);

    localparam int CW = ib_cnt_w(DEPTH_BYTES);

    logic          fetching_q, fetching_d;
    logic          gap_q, gap_d;
    logic [29:0]   va_q, va_d;
    logic [1:0]    skip_q, skip_d;
    logic [CW-1:0] cnt;
    logic          fill;

    // Free space only grows while a request waits, so the decoded request stays up until ack.
    assign ib_req_h = fetching_q & ~gap_q & ((DEPTH_BYTES - int'(cnt)) >= IB_LW_BYTES);
    assign fill     = ib_req_h & mem_ack_h & ~ld_pc_h;

    always_comb begin
        fetching_d = fetching_q;
        gap_d      = 1'b0;
        va_d       = va_q;
        skip_d     = skip_q;
        if (ld_pc_h) begin
            fetching_d = 1'b1;
            gap_d      = 1'b1;
            va_d       = pc_h[31:2];
            skip_d     = pc_h[1:0];
        end else if (fill) begin
            va_d   = va_q + 30'd1;
            skip_d = 2'd0;
        end
    end

    always_ff @(posedge buf_m_clk_l or posedge reset_h) begin
        if (reset_h) begin
            fetching_q <= 1'b0;
            gap_q      <= 1'b0;
            va_q       <= '0;
            skip_q     <= '0;
        end else begin
            fetching_q <= fetching_d;
            gap_q      <= gap_d;
            va_q       <= va_d;
            skip_q     <= skip_d;
        end
    end

    ib_byte_queue #(.DEPTH_BYTES(DEPTH_BYTES)) u_queue (
        .clk_i       (buf_m_clk_l),
        .rst_i       (reset_h),
        .flush_i     (ld_pc_h),
        .shift_i     (ib_shift_h),
        .fill_i      (fill),
        .fill_data_i (mem_data_h),
        .fill_skip_i (skip_q),
        .cnt_o       (cnt),
        .head_o      (xbuf_h),
        .bvalid_o    (ib_bvalid_h),
        .err_o       (ib_err_h)
    );

    assign ib_va_h  = va_q;
    assign ib_cnt_h = 4'(cnt);

endmodule

// File: tb/tb_ib_prefetch.sv
// tb/tb_ib_prefetch.sv - randomized and directed bench for ib_prefetch against a byte-queue model
module tb_ib_prefetch;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset_h = 1'b1;
    logic        ld_pc_h = 1'b0;
    logic [31:0] pc_h = '0;
    logic [1:0]  ib_shift_h = '0;
    logic        ib_req_h;
    logic [29:0] ib_va_h;
    logic        mem_ack_h = 1'b0;
    logic [31:0] mem_data_h = '0;
    logic [15:0] xbuf_h;
    logic [1:0]  ib_bvalid_h;
    logic [3:0]  ib_cnt_h;
    logic        ib_err_h;

    int n_checks = 0;
    int n_fail   = 0;

    ib_prefetch #(.DEPTH_BYTES(D)) dut (
        .buf_m_clk_l (clk),
        .reset_h     (reset_h),
        .ld_pc_h     (ld_pc_h),
        .pc_h        (pc_h),
        .ib_shift_h  (ib_shift_h),
        .ib_req_h    (ib_req_h),
        .ib_va_h     (ib_va_h),
        .mem_ack_h   (mem_ack_h),
        .mem_data_h  (mem_data_h),
        .xbuf_h      (xbuf_h),
        .ib_bvalid_h (ib_bvalid_h),
        .ib_cnt_h    (ib_cnt_h),
        .ib_err_h    (ib_err_h)
    );

    always #5 clk = ~clk;

    // Reference model: the buffer is a plain byte queue.
    byte unsigned mq[$];
    bit           m_fetch, m_gap, m_err;
    logic [29:0]  m_va;
    int           m_skip;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_req();
        return m_fetch && !m_gap && (D - mq.size()) >= 4;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_fetch = 0; m_gap = 0; m_err = 0; m_va = '0; m_skip = 0;
    endtask

    task automatic m_step(input bit ld, input logic [31:0] pc, input int sh, input bit ack,
                          input logic [31:0] data);
        bit req;
        req = m_req();
        if (ld) begin
            mq.delete();
            m_va = pc[31:2]; m_skip = int'(pc[1:0]); m_fetch = 1; m_gap = 1;
        end else begin
            m_gap = 0;
            if (sh == 3 || sh > mq.size()) m_err = 1;
            else repeat (sh) void'(mq.pop_front());
            if (ack && req) begin
                for (int k = m_skip; k < 4; k++) mq.push_back(data[8*k +: 8]);
                m_skip = 0;
                m_va = m_va + 30'd1;
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] b0, b1;
        b0 = mq.size() > 0 ? mq[0] : 8'h00;
        b1 = mq.size() > 1 ? mq[1] : 8'h00;
        check_eq("cnt",    32'(ib_cnt_h),    32'(mq.size()));
        check_eq("xbuf",   32'(xbuf_h),      {16'h0, b1, b0});
        check_eq("bvalid", 32'(ib_bvalid_h), {30'h0, mq.size() > 1, mq.size() > 0});
        check_eq("req",    32'(ib_req_h),    32'(m_req()));
        check_eq("va",     32'(ib_va_h),     32'(m_va));
        check_eq("err",    32'(ib_err_h),    32'(m_err));
    endtask

    task automatic cyc(input bit ld, input logic [31:0] pc, input int sh, input bit ack,
                       input logic [31:0] data);
        ld_pc_h = ld; pc_h = pc; ib_shift_h = 2'(sh); mem_ack_h = ack; mem_data_h = data;
        @(posedge clk);
        m_step(ld, pc, sh, ack, data);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(0, 32'h0, 0, 0, 32'h0);
    endtask

    // Asserted between edges so the asynchronous clear is visible before any clock.
    task automatic do_reset();
        ld_pc_h = 0; ib_shift_h = 0; mem_ack_h = 0;
        #2 reset_h = 1'b1;
        #1;
        m_reset();
        compare_all();
        @(posedge clk);
        #1 reset_h = 1'b0;
        compare_all();
    endtask

    function automatic logic [31:0] stream_word(input logic [29:0] va);
        logic [31:0] w;
        int          j;
        for (int k = 0; k < 4; k++) begin
            j = int'(va - 30'h400) * 4 + k + 1;
            w[8*k +: 8] = 8'(j * 17);
        end
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] nb;
        int         sh, r;
        m_reset();
        @(posedge clk);
        #1;
        compare_all();
        reset_h = 1'b0;

        // Nothing is requested before the first PC load.
        repeat (3) idle();

        // T1: pc 0x1002 keeps the upper half of the first longword.
        cyc(1, 32'h0000_1002, 0, 0, 0);
        check_eq("t1_gap_req", 32'(ib_req_h), 32'd0);
        idle();
        check_eq("t1_req", 32'(ib_req_h), 32'd1);
        check_eq("t1_va", 32'(ib_va_h), 32'h400);
        cyc(0, 0, 0, 1, 32'h4433_2211);
        check_eq("t1_cnt", 32'(ib_cnt_h), 32'd2);
        check_eq("t1_xbuf", 32'(xbuf_h), 32'h4433);
        check_eq("t1_bvalid", 32'(ib_bvalid_h), 32'd3);
        check_eq("t1_va_inc", 32'(ib_va_h), 32'h401);

        // T2: streaming with immediate acks, bytes must retire in order.
        cyc(1, 32'h0000_1000, 0, 0, 0);
        nb = 8'h11;
        for (int c = 0; c < 24; c++) begin
            sh = mq.size() >= 2 ? 2 : 0;
            if (sh == 2) begin
                check_eq("t2_order0", 32'(xbuf_h[7:0]), 32'(nb));
                check_eq("t2_order1", 32'(xbuf_h[15:8]), 32'(8'(nb + 8'h11)));
                nb = 8'(nb + 8'h22);
            end
            cyc(0, 0, sh, m_req(), stream_word(m_va));
            check_eq("t2_cnt_le8", 32'(ib_cnt_h <= 4'd8), 32'd1);
        end

        // T3: full-queue request gating.
        cyc(1, 32'h0, 0, 0, 0);
        for (int c = 0; c < 12 && mq.size() < 8; c++) cyc(0, 0, 0, m_req(), $urandom);
        check_eq("t3_full_cnt", 32'(ib_cnt_h), 32'd8);
        check_eq("t3_full_req", 32'(ib_req_h), 32'd0);
        cyc(0, 0, 1, 0, 0);
        check_eq("t3_cnt7", 32'(ib_cnt_h), 32'd7);
        check_eq("t3_req7", 32'(ib_req_h), 32'd0);
        cyc(0, 0, 2, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check_eq("t3_cnt4", 32'(ib_cnt_h), 32'd4);
        check_eq("t3_req4", 32'(ib_req_h), 32'd1);

        // T4: shift and fill in one cycle.
        cyc(1, 32'h1, 0, 0, 0);
        idle();
        cyc(0, 0, 0, 1, 32'h0302_0100);
        check_eq("t4_cnt3", 32'(ib_cnt_h), 32'd3);
        cyc(0, 0, 2, 1, 32'hDDCC_BBAA);
        check_eq("t4_cnt5", 32'(ib_cnt_h), 32'd5);
        check_eq("t4_xbuf", 32'(xbuf_h), 32'hAA03);

        // T5: PC load abandons the outstanding request and its ack.
        cyc(1, 32'h0, 0, 0, 0);
        idle();
        cyc(1, 32'h2003, 0, 1, 32'h1122_3344);
        check_eq("t5_cnt0", 32'(ib_cnt_h), 32'd0);
        check_eq("t5_gap", 32'(ib_req_h), 32'd0);
        idle();
        check_eq("t5_va", 32'(ib_va_h), 32'h800);
        cyc(0, 0, 0, 1, 32'h8765_4321);
        check_eq("t5_cnt1", 32'(ib_cnt_h), 32'd1);
        check_eq("t5_xbuf", 32'(xbuf_h), 32'h0087);

        // T6: illegal shifts.
        cyc(0, 0, 2, 0, 0);
        check_eq("t6_cnt1", 32'(ib_cnt_h), 32'd1);
        check_eq("t6_err", 32'(ib_err_h), 32'd1);
        repeat (3) idle();
        check_eq("t6_err_sticky", 32'(ib_err_h), 32'd1);
        cyc(0, 0, 0, 1, 32'hA5A5_5A5A);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 3, 0, 0);
        check_eq("t6_sh3_cnt4", 32'(ib_cnt_h), 32'd4);
        do_reset();
        check_eq("t6_err_cleared", 32'(ib_err_h), 32'd0);

        // Randomized traffic against the model.
        cyc(1, $urandom, 0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                cyc(1, $urandom, 0, 0, 0);
            end
            r  = $urandom_range(0, 15);
            sh = r < 4 ? 0 : (r < 8 ? 1 : (r < 15 ? 2 : 3));
            cyc($urandom_range(0, 23) == 0, $urandom, sh,
                m_req() ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
                $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
